// File: rtl/vga_cell_scanner.sv
// Raster timing generator for 640x480@60 VGA that walks the screen in coarse cells,
// feeds a combinational pattern layer and drives blank-masked, sync-aligned RGB.
module vga_cell_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_W   = 10,
  parameter int CELL_H   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scroll_en,
  input  logic [5:0] layer_rgb,
  output logic [5:0] cell_x,
  output logic [4:0] cell_y,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SHW     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int SVW     = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [HW-1:0]  H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  H_SYNC_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SHW-1:0] H_SUB_LAST  = SHW'(CELL_W - 1);
  localparam logic [SVW-1:0] V_SUB_LAST  = SVW'(CELL_H - 1);

  // Stage 0: raster and cell counters
  logic [HW-1:0]  r_hcount;
  logic [VW-1:0]  r_vcount;
  logic [SHW-1:0] r_hsub;
  logic [SVW-1:0] r_vsub;
  logic [5:0]     r_hcell;
  logic [4:0]     r_vcell;
  logic [5:0]     r_offset;

  // Stage 1 / stage 2 pipeline registers
  logic [5:0] r_cell_x;
  logic [4:0] r_cell_y;
  logic       r_active1, r_hs1, r_vs1, r_fs1;
  logic [5:0] r_rgb;
  logic       r_hsync, r_vsync, r_frame_start;

  logic w_h_last, w_v_last, w_h_act, w_v_act, w_active0, w_hs0, w_vs0, w_fs0;

  always_comb begin
    w_h_last  = (r_hcount == H_LAST);
    w_v_last  = (r_vcount == V_LAST);
    w_h_act   = (r_hcount < H_ACT_END);
    w_v_act   = (r_vcount < V_ACT_END);
    w_active0 = w_h_act && w_v_act;
    w_hs0     = !((r_hcount >= H_SYNC_BEG) && (r_hcount < H_SYNC_END));
    w_vs0     = !((r_vcount >= V_SYNC_BEG) && (r_vcount < V_SYNC_END));
    w_fs0     = (r_hcount == '0) && (r_vcount == '0);
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsub   <= '0;
      r_hcell  <= '0;
      r_vsub   <= '0;
      r_vcell  <= '0;
      r_offset <= '0;
    end else begin
      r_hcount <= w_h_last ? '0 : r_hcount + HW'(1);

      if (w_h_last) begin
        r_hsub  <= '0;
        r_hcell <= '0;
      end else if (w_h_act) begin
        if (r_hsub == H_SUB_LAST) begin
          r_hsub  <= '0;
          r_hcell <= r_hcell + 6'd1;
        end else begin
          r_hsub <= r_hsub + SHW'(1);
        end
      end

      if (w_h_last) begin
        r_vcount <= w_v_last ? '0 : r_vcount + VW'(1);
        if (w_v_last) begin
          r_vsub  <= '0;
          r_vcell <= '0;
        end else if (w_v_act) begin
          if (r_vsub == V_SUB_LAST) begin
            r_vsub  <= '0;
            r_vcell <= r_vcell + 5'd1;
          end else begin
            r_vsub <= r_vsub + SVW'(1);
          end
        end
      end

      // Offset moves on the same edge as the frame wrap, so pixel 0 of the next frame sees it.
      if (w_h_last && w_v_last && scroll_en) begin
        r_offset <= r_offset + 6'd1;
      end
    end
  end

  // Cell coordinates only load on active pixels; during blanking they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cell_x  <= '0;
      r_cell_y  <= '0;
      r_active1 <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_fs1     <= 1'b0;
    end else begin
      if (w_active0) begin
        r_cell_x <= r_hcell + r_offset;
        r_cell_y <= r_vcell;
      end
      r_active1 <= w_active0;
      r_hs1     <= w_hs0;
      r_vs1     <= w_vs0;
      r_fs1     <= w_fs0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= r_active1 ? layer_rgb : 6'd0;
      r_hsync       <= r_hs1;
      r_vsync       <= r_vs1;
      r_frame_start <= r_fs1;
    end
  end

  assign cell_x      = r_cell_x;
  assign cell_y      = r_cell_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_cell_scanner.sv
// Scoreboard bench for vga_cell_scanner on a shrunken raster so that many frames,
// including a full 64-frame scroll wrap, fit in a short run.
module tb_vga_cell_scanner;

  localparam int HA = 33, HFP = 3, HS = 5, HBP = 4;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 2;
  localparam int CW = 3, CH = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic       clk = 1'b1;
  logic       rst;
  logic       scroll_en;
  logic [5:0] layer_rgb;
  logic [5:0] cell_x;
  logic [4:0] cell_y;
  logic       hsync, vsync;
  logic [5:0] rgb;
  logic       frame_start;

  always #5 clk = ~clk;

  vga_cell_scanner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CELL_W(CW), .CELL_H(CH)
  ) dut (
    .clk(clk), .rst(rst), .scroll_en(scroll_en), .layer_rgb(layer_rgb),
    .cell_x(cell_x), .cell_y(cell_y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_start(frame_start)
  );

  typedef struct {
    logic [5:0] cx;
    logic [4:0] cy;
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
    logic       fs;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int at);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, at);
    end
  endtask

  // Reference model: the raster is a single position 0..FT-1 within the frame;
  // everything else follows from division by the line and cell sizes.
  int m_pos = 0, m_off = 0, m_cx = 0, m_cy = 0;
  bit m_act1 = 0, m_hs1 = 1, m_vs1 = 1, m_fs1 = 0;

  task automatic step(input bit r, input bit se, input logic [5:0] l);
    exp_t e;
    int   h, v;
    @(negedge clk);
    rst = r; scroll_en = se; layer_rgb = l;
    cyc++;
    e.cyc = cyc;
    if (r) begin
      e.cx = 0; e.cy = 0; e.hs = 1; e.vs = 1; e.rgb = 0; e.fs = 0;
      m_pos = 0; m_off = 0; m_cx = 0; m_cy = 0;
      m_act1 = 0; m_hs1 = 1; m_vs1 = 1; m_fs1 = 0;
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      e.rgb = m_act1 ? l : 6'd0;
      e.hs  = m_hs1;
      e.vs  = m_vs1;
      e.fs  = m_fs1;
      if (h < HA && v < VA) begin
        m_cx = (h / CW + m_off) % 64;
        m_cy = v / CH;
      end
      e.cx   = 6'(m_cx);
      e.cy   = 5'(m_cy);
      m_act1 = (h < HA) && (v < VA);
      m_hs1  = !(h >= HA + HFP && h < HA + HFP + HS);
      m_vs1  = !(v >= VA + VFP && v < VA + VFP + VS);
      m_fs1  = (m_pos == 0);
      if (m_pos == FT - 1 && se) m_off = (m_off + 1) % 64;
      m_pos = (m_pos + 1) % FT;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: pops one expectation per output cycle and also measures sync/frame intervals.
  int hs_run = 0, vs_run = 0, hs_gap = 0, fs_gap = 0;
  bit hs_seen = 0, fs_seen = 0, hs_prev = 1;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("cell_x",      32'(cell_x),      32'(e.cx),  e.cyc);
        check("cell_y",      32'(cell_y),      32'(e.cy),  e.cyc);
        check("hsync",       32'(hsync),       32'(e.hs),  e.cyc);
        check("vsync",       32'(vsync),       32'(e.vs),  e.cyc);
        check("rgb",         32'(rgb),         32'(e.rgb), e.cyc);
        check("frame_start", 32'(frame_start), 32'(e.fs),  e.cyc);
        if (rst) begin
          hs_run = 0; vs_run = 0; hs_seen = 0; fs_seen = 0; hs_prev = 1;
        end else begin
          if (!hsync) hs_run++;
          else if (hs_run > 0) begin
            check("hsync_low_len", hs_run, HS, e.cyc);
            hs_run = 0;
          end
          if (!vsync) vs_run++;
          else if (vs_run > 0) begin
            check("vsync_low_len", vs_run, VS * HT, e.cyc);
            vs_run = 0;
          end
          if (hs_seen) hs_gap++;
          if (!hsync && hs_prev) begin
            if (hs_seen) check("hsync_period", hs_gap, HT, e.cyc);
            hs_seen = 1;
            hs_gap  = 0;
          end
          hs_prev = hsync;
          if (fs_seen) fs_gap++;
          if (frame_start) begin
            if (fs_seen) check("frame_period", fs_gap, FT, e.cyc);
            fs_seen = 1;
            fs_gap  = 0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; scroll_en = 1'b0; layer_rgb = 6'd0;
    repeat (3) step(1'b1, 1'b0, 6'd0);
    // Two frames without scroll, random layer colours.
    repeat (2 * FT) step(1'b0, 1'b0, 6'($urandom));
    // Reset held three cycles in the middle of a line, mid-frame.
    repeat (FT / 2 + HT / 3) step(1'b0, 1'b0, 6'($urandom));
    repeat (3) step(1'b1, 1'b0, 6'($urandom));
    // Scroll every frame long enough for the offset to wrap 63 -> 0.
    repeat (66 * FT) step(1'b0, 1'b1, 6'($urandom));
    // Constant colour with scroll toggling randomly; blanking must mask it.
    repeat (2 * FT) step(1'b0, 1'($urandom), 6'b110011);
    // Reset while vsync is low: the pulse must not be extended.
    while (m_pos != (VA + VFP) * HT + 5) step(1'b0, 1'b0, 6'($urandom));
    repeat (2) step(1'b1, 1'b0, 6'($urandom));
    repeat (3 * HT) step(1'b0, 1'b0, 6'($urandom));
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0, cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
